// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_pulse input conditioning stage.
package debounce_pkg;

    localparam int unsigned DEB_STABLE_DEFAULT  = 8;
    localparam int unsigned DEB_PRESS_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } deb_state_t;

endpackage

// File: rtl/debounce_pulse_sync_2ff.sv
// 1-bit two-stage synchroniser for an asynchronous input; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/debounce_pulse.sv
// Button debouncer: optional two-flop synchroniser (DEBOUNCE_SYNC_EN), stable-count FSM,
// registered level, single-cycle rise/fall pulses and a wrapping press counter.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEB_STABLE_DEFAULT,
    parameter int unsigned PRESS_W       = DEB_PRESS_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_in,
    output logic               level,
    output logic               rise,
    output logic               fall,
    output logic [PRESS_W-1:0] press_count
);

    localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    deb_state_t       state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             accept_rise, accept_fall;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_in),
        .q    (s)
    );
`else
    always_comb s = btn_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_LO;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // cnt holds the number of consecutive samples already seen differing from level
    always_comb begin
        next_state  = state;
        cnt_next    = '0;
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        case (state)
            IDLE_LO: begin
                if (s) begin
                    next_state = WAIT_HI;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    next_state = IDLE_LO;
                end else if (cnt == CNT_LAST) begin
                    next_state  = IDLE_HI;
                    accept_rise = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    next_state = WAIT_LO;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (s) begin
                    next_state = IDLE_HI;
                end else if (cnt == CNT_LAST) begin
                    next_state  = IDLE_LO;
                    accept_fall = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: next_state = IDLE_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level       <= 1'b0;
            rise        <= 1'b0;
            fall        <= 1'b0;
            press_count <= '0;
        end else begin
            rise <= accept_rise;
            fall <= accept_fall;
            if (accept_rise) begin
                level       <= 1'b1;
                press_count <= press_count + PRESS_W'(1);
            end else if (accept_fall) begin
                level <= 1'b0;
            end
        end
    end

endmodule
